// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative IEEE-754 square root for any EXP_W/FRAC_W format.
// A restoring radix-2 digit recurrence produces one root bit per cycle.
// Denormal inputs are normalised. Special operands skip the recurrence.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low; clears all state
//   start  - request; accepted only in IDLE or DONE
//   op     - operand; captured on an accepted start
//   rm     - rounding mode (000 RNE, 001 RZ, 010 RD, 011 RU, 100 RMM, others RNE)
//   result - root; held until the next done
//   flags  - {NV, DZ, OF, UF, NX}; held with result
//   busy   - high in PREP, ITER and ROUND
//   done   - one-cycle pulse when result and flags are valid
module fsqrt_iter #(
    parameter int unsigned EXP_W  = 11,
    parameter int unsigned FRAC_W = 52
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [EXP_W+FRAC_W:0] op,
    input  logic [2:0]            rm,
    output logic [EXP_W+FRAC_W:0] result,
    output logic [4:0]            flags,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned W     = 1 + EXP_W + FRAC_W;
    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned NITER = FRAC_W + 2;
    localparam int unsigned XW    = 2 * NITER;
    localparam int unsigned RW    = NITER + 2;
    localparam int unsigned TW    = EXP_W + 1;
    localparam int unsigned LZW   = $clog2(FRAC_W + 1);
    localparam int unsigned CW    = $clog2(NITER);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     op_q, op_d;
    logic [2:0]       rm_q, rm_d;
    logic [XW-1:0]    x_q, x_d;       // radicand, consumed two bits per cycle
    logic [RW-1:0]    r_q, r_d;       // partial remainder
    logic [NITER-1:0] q_q, q_d;       // partial root
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EXP_W-1:0] eb_q, eb_d;     // biased root exponent before rounding carry
    logic [W-1:0]     result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    // Operand unpack and classification
    logic               op_sign;
    logic [EXP_W-1:0]   op_exp;
    logic [FRAC_W-1:0]  op_frac;
    logic               exp_ones, exp_zero, frac_zero;
    logic [LZW-1:0]     lz;
    logic [FRAC_W:0]    mant;
    logic [TW-1:0]      t;
    logic [NITER-1:0]   rad;

    assign op_sign   = op_q[W-1];
    assign op_exp    = op_q[W-2:FRAC_W];
    assign op_frac   = op_q[FRAC_W-1:0];
    assign exp_ones  = &op_exp;
    assign exp_zero  = ~|op_exp;
    assign frac_zero = ~|op_frac;

    // Leading-zero count of the fraction; the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (op_frac[i]) lz = LZW'(FRAC_W - 1 - i);
        end
    end

    // A denormal is 0.f * 2^(1-BIAS); shifting by lz+1 puts its MSB at the integer
    // position, so the unbiased exponent is -BIAS-lz.
    assign mant = exp_zero ? ({1'b0, op_frac} << (lz + LZW'(1))) : {1'b1, op_frac};

    // t = e + 2*BIAS is never negative, has the parity of e, and t>>1 is er+BIAS.
    assign t   = exp_zero ? (TW'(BIAS) - TW'(lz)) : (TW'(op_exp) + TW'(BIAS));
    assign rad = t[0] ? {mant, 1'b0} : {1'b0, mant};

    // Recurrence step
    logic [1:0]    top2;
    logic [RW+1:0] rem_ext;
    logic [RW-1:0] trial, diff;
    logic          fits;

    assign top2    = x_q[XW-1 -: 2];
    assign rem_ext = {r_q, top2};
    assign trial   = {q_q, 2'b01};
    assign fits    = rem_ext >= {2'b00, trial};
    assign diff    = rem_ext[RW-1:0] - trial;

    // Rounding; Q is {1, FRAC_W fraction bits, guard}
    logic             guard, lsb, sticky, inc;
    logic [FRAC_W:0]  frac_sum;
    logic [EXP_W-1:0] exp_r;

    assign guard  = q_q[0];
    assign lsb    = q_q[1];
    assign sticky = |r_q;

    always_comb begin
        unique case (rm_q)
            3'b001, 3'b010: inc = 1'b0;
            3'b011:         inc = guard | sticky;
            3'b100:         inc = guard;
            default:        inc = guard & (sticky | lsb);
        endcase
    end

    assign frac_sum = {1'b0, q_q[NITER-2:1]} + {{FRAC_W{1'b0}}, inc};
    assign exp_r    = eb_q + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rm_d     = rm_q;
        x_d      = x_q;
        r_d      = r_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        eb_d     = eb_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_PREP;
                    op_d    = op;
                    rm_d    = rm;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                state_d = S_DONE;
                if (exp_ones && !frac_zero) begin
                    result_d = QNAN;
                    flags_d  = {~op_frac[FRAC_W-1], 4'b0000};
                end else if (exp_zero && frac_zero) begin
                    result_d = {op_sign, {(W-1){1'b0}}};
                    flags_d  = 5'b00000;
                end else if (op_sign) begin
                    result_d = QNAN;
                    flags_d  = 5'b10000;
                end else if (exp_ones) begin
                    result_d = PINF;
                    flags_d  = 5'b00000;
                end else begin
                    state_d = S_ITER;
                    x_d     = {rad, {NITER{1'b0}}};
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = '0;
                    eb_d    = t[EXP_W:1];
                end
            end
            S_ITER: begin
                x_d   = x_q << 2;
                r_d   = fits ? diff : rem_ext[RW-1:0];
                q_d   = {q_q[NITER-2:0], fits};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NITER - 1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                result_d = {1'b0, exp_r, frac_sum[FRAC_W-1:0]};
                flags_d  = {4'b0000, guard | sticky};
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rm_q     <= '0;
            x_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            eb_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rm_q     <= rm_d;
            x_q      <= x_d;
            r_q      <= r_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            eb_q     <= eb_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign busy   = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_ROUND);
    assign done   = (state_q == S_DONE);

endmodule
